// File: rtl/serv_pkg.sv
// Shared definitions for the serial buffer register: shift-counter FSM states
// and parameter legality checks used at elaboration.
package serv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      REM,
      COUNT,
      DONE
   } sh_state_e;

   function automatic bit legal_w(input int unsigned w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8);
   endfunction

   function automatic bit legal_xlen(input int unsigned xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/serv_shcnt.sv
// Shift-amount counter: captures shamt at the end of operand fill, optionally
// spends one cycle exposing the sub-W remainder, then counts down by W.
module serv_shcnt
   import serv_pkg::*;
#(
   parameter  int W    = 1,
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN),
   localparam int LB   = $clog2(W),
   localparam int RW   = (LB > 0) ? LB : 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic           i_init,
   input  logic           i_cnt_done,
   input  logic           i_shift_op,
   input  logic           i_right_shift_op,
   input  logic [SHW-1:0] i_shamt,
   output logic           o_fill,
   output logic           o_sh_done,
   output logic           o_sh_done_r,
   output logic [RW-1:0]  o_shift_rem,
   output logic           o_busy
);

   sh_state_e      state_q, state_d;
   logic [SHW:0]   cnt_q, cnt_d;
   logic [RW-1:0]  rem_q, rem_d;
   logic [SHW:0]   cnt_dec;
   logic [SHW-1:0] shamt_rem;

   assign cnt_dec   = cnt_q - (SHW+1)'(W);
   assign shamt_rem = i_shamt & SHW'(W - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      if (!i_shift_op) begin
         state_d = IDLE;
         cnt_d   = '0;
         rem_d   = '0;
      end else begin
         unique case (state_q)
            IDLE:  if (i_init && i_en) state_d = FILL;
            FILL: begin
               if (i_cnt_done) begin
                  cnt_d   = {1'b0, i_shamt};
                  rem_d   = shamt_rem[RW-1:0];
                  state_d = (i_right_shift_op && (shamt_rem != '0)) ? REM : COUNT;
               end
            end
            REM:   state_d = COUNT;
            COUNT: begin
               cnt_d = cnt_dec;
               if (cnt_dec[SHW]) state_d = DONE;
            end
            DONE:  state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
      end
   end

   // The remainder register is only loaded at fill exit and cleared on return
   // to IDLE, so it already reads zero outside the hold window.
   assign o_shift_rem = rem_q;
   assign o_fill      = (state_q == FILL);
   assign o_sh_done   = (state_q == COUNT) && cnt_dec[SHW];
   assign o_sh_done_r = cnt_q[SHW];
   assign o_busy      = (state_q == COUNT) || (state_q == DONE);

endmodule

// File: rtl/serv_bufreg3.sv
// Serial data buffer: shifts operand bits in W at a time, exposes byte-lane
// aligned data, and drives the shift-amount counter from its own low bits.
module serv_bufreg3
   import serv_pkg::*;
#(
   parameter  int W    = 1,
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN),
   localparam int LB   = $clog2(W),
   localparam int BW   = $clog2(XLEN/8),
   localparam int RW   = (LB > 0) ? LB : 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_init,
   input  logic            i_cnt_done,
   input  logic            i_byte_valid,
   input  logic            i_op_b_sel,
   input  logic            i_shift_op,
   input  logic            i_right_shift_op,
   input  logic            i_load,
   input  logic [BW-1:0]   i_lsb,
   input  logic [W-1:0]    i_rs2,
   input  logic [W-1:0]    i_imm,
   output logic [W-1:0]    o_op_b,
   output logic [W-1:0]    o_q,
   output logic            o_sh_done,
   output logic            o_sh_done_r,
   output logic [RW-1:0]   o_shift_rem,
   output logic            o_busy,
   output logic [XLEN-1:0] o_dat,
   input  logic [XLEN-1:0] i_dat
);

   if (!legal_w(W) || !legal_xlen(XLEN)) begin : g_bad_param
      $error("serv_bufreg3: unsupported W/XLEN combination");
   end

   logic [XLEN-1:0] dat_q, dat_d;
   logic            fill;
   logic            shift_en;

   assign o_op_b   = i_op_b_sel ? i_rs2 : i_imm;
   assign shift_en = ((i_en && i_byte_valid) || fill) && !i_load;

   always_comb begin
      dat_d = dat_q;
      if (i_load)
         dat_d = i_dat;
      else if (shift_en)
         dat_d = {o_op_b, dat_q[XLEN-1:W]};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         dat_q <= '0;
      else
         dat_q <= dat_d;
   end

   assign o_q   = dat_q[{i_lsb, 3'b000} +: W];
   assign o_dat = dat_q;

   // shamt is taken from the value being written this cycle so the counter
   // sees the fully filled operand on the last fill beat.
   serv_shcnt #(
      .W    (W),
      .XLEN (XLEN)
   ) u_shcnt (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_en             (i_en),
      .i_init           (i_init),
      .i_cnt_done       (i_cnt_done),
      .i_shift_op       (i_shift_op),
      .i_right_shift_op (i_right_shift_op),
      .i_shamt          (dat_d[SHW-1:0]),
      .o_fill           (fill),
      .o_sh_done        (o_sh_done),
      .o_sh_done_r      (o_sh_done_r),
      .o_shift_rem      (o_shift_rem),
      .o_busy           (o_busy)
   );

endmodule

// File: tb/tb_serv_bufreg3.sv
// Bench for serv_bufreg3 across several W/XLEN configurations, checked
// against an arithmetic reference model of the data path and shift timing.
module tb_serv_bufreg3;

   localparam int NI = 5;

   function automatic int w_of(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 4;
         default: return 8;
      endcase
   endfunction

   function automatic int x_of(input int i);
      return (i == 4) ? 64 : 32;
   endfunction

   logic        clk = 1'b0;
   logic        rst, en, init, cnt_done, bv, op_b_sel, shift_op, right, load;
   logic [2:0]  lsb;
   logic [7:0]  rs2, imm;
   logic [63:0] idat;

   logic [63:0]    obs_dat [NI];
   logic [7:0]     obs_q   [NI];
   logic [7:0]     obs_opb [NI];
   logic [2:0]     obs_rem [NI];
   logic [NI-1:0]  obs_shd, obs_shdr, obs_busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] mmod [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int GW  = w_of(g);
      localparam int GX  = x_of(g);
      localparam int GBW = $clog2(GX/8);
      localparam int GRW = (GW > 1) ? $clog2(GW) : 1;
      logic [GW-1:0]  opb, q;
      logic [GX-1:0]  dat;
      logic [GRW-1:0] rem;
      logic           shd, shdr, busy;

      serv_bufreg3 #(.W(GW), .XLEN(GX)) dut (
         .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init),
         .i_cnt_done(cnt_done), .i_byte_valid(bv), .i_op_b_sel(op_b_sel),
         .i_shift_op(shift_op), .i_right_shift_op(right), .i_load(load),
         .i_lsb(lsb[GBW-1:0]), .i_rs2(rs2[GW-1:0]), .i_imm(imm[GW-1:0]),
         .o_op_b(opb), .o_q(q), .o_sh_done(shd), .o_sh_done_r(shdr),
         .o_shift_rem(rem), .o_busy(busy), .o_dat(dat), .i_dat(idat[GX-1:0])
      );

      assign obs_dat[g]  = 64'(dat);
      assign obs_q[g]    = 8'(q);
      assign obs_opb[g]  = 8'(opb);
      assign obs_rem[g]  = 3'(rem);
      assign obs_shd[g]  = shd;
      assign obs_shdr[g] = shdr;
      assign obs_busy[g] = busy;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wmask(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] xmask(input int x);
      return (x == 64) ? '1 : 64'hFFFF_FFFF;
   endfunction

   // Reference: dat is a plain XLEN-bit word; new bits enter at the top.
   function automatic logic [63:0] mshift(input logic [63:0] m, input int w, input int x,
                                          input logic [7:0] ob);
      logic [63:0] o;
      o = {56'b0, ob} & wmask(w);
      return ((m >> w) | (o << (x - w))) & xmask(x);
   endfunction

   task automatic start_fill(input int i, input logic [63:0] word);
      int w, n;
      w = w_of(i);
      n = x_of(i) / w;
      shift_op = 1'b0; init = 1'b0; cnt_done = 1'b0;
      @(negedge clk);
      shift_op = 1'b1; init = 1'b1; en = 1'b1;
      @(negedge clk);
      init = 1'b0;
      chk($sformatf("fill_busy[%0d]", i), 64'(obs_busy[i]), 64'd0);
      for (int k = 0; k < n; k++) begin
         rs2 = 8'(word >> (k * w));
         cnt_done = (k == n - 1);
         @(negedge clk);
      end
      cnt_done = 1'b0;
   endtask

   task automatic run_shift(input int i, input logic [63:0] word, input logic rgt);
      int w, shamt, remv, kdone;
      w     = w_of(i);
      shamt = int'(word & ((x_of(i) == 64) ? 64'h3F : 64'h1F));
      remv  = shamt % w;
      kdone = shamt / w + 1;
      right = rgt;
      start_fill(i, word);
      chk($sformatf("rem_exit[%0d]", i), 64'(obs_rem[i]), 64'(remv));
      if (rgt && remv != 0) begin
         chk($sformatf("rem_busy[%0d]", i), 64'(obs_busy[i]), 64'd0);
         chk($sformatf("rem_shd[%0d]", i), 64'(obs_shd[i]), 64'd0);
         @(negedge clk);
      end
      for (int k = 1; k <= kdone; k++) begin
         chk($sformatf("cnt_busy[%0d] k=%0d", i, k), 64'(obs_busy[i]), 64'd1);
         chk($sformatf("cnt_shd[%0d] k=%0d sh=%0d", i, k, shamt), 64'(obs_shd[i]),
             64'(k == kdone));
         if (k == 1) chk($sformatf("cnt_shdr[%0d]", i), 64'(obs_shdr[i]), 64'd0);
         @(negedge clk);
      end
      chk($sformatf("done_busy[%0d]", i), 64'(obs_busy[i]), 64'd1);
      chk($sformatf("done_shd[%0d]", i), 64'(obs_shd[i]), 64'd0);
      chk($sformatf("done_shdr[%0d]", i), 64'(obs_shdr[i]), 64'd1);
      chk($sformatf("done_rem[%0d]", i), 64'(obs_rem[i]), 64'(remv));
      shift_op = 1'b0;
      @(negedge clk);
      chk($sformatf("idle_busy[%0d]", i), 64'(obs_busy[i]), 64'd0);
      chk($sformatf("idle_rem[%0d]", i), 64'(obs_rem[i]), 64'd0);
      chk($sformatf("idle_shdr[%0d]", i), 64'(obs_shdr[i]), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wd;
      int lsbi, ii;
      logic [7:0] ob;

      rst = 1'b1; en = 1'b1; init = 1'b0; cnt_done = 1'b0; bv = 1'b1;
      op_b_sel = 1'b0; shift_op = 1'b1; right = 1'b0; load = 1'b1;
      lsb = 3'd0; rs2 = 8'hFF; imm = 8'hFF; idat = '1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_dat[%0d]", i), obs_dat[i], 64'd0);
         chk($sformatf("rst_q[%0d]", i), 64'(obs_q[i]), 64'd0);
         chk($sformatf("rst_shd[%0d]", i), 64'(obs_shd[i]), 64'd0);
         chk($sformatf("rst_shdr[%0d]", i), 64'(obs_shdr[i]), 64'd0);
         chk($sformatf("rst_busy[%0d]", i), 64'(obs_busy[i]), 64'd0);
         mmod[i] = '0;
      end
      rst = 1'b0; load = 1'b0; shift_op = 1'b0;

      for (int c = 0; c < 60; c++) begin
         en       = 1'($urandom_range(0, 1));
         bv       = 1'($urandom_range(0, 1));
         op_b_sel = 1'($urandom_range(0, 1));
         init     = 1'($urandom_range(0, 1));
         imm      = 8'($urandom);
         rs2      = 8'($urandom);
         load     = ($urandom_range(0, 7) == 0);
         idat     = {$urandom, $urandom};
         lsb      = 3'($urandom);
         #1;
         for (int i = 0; i < NI; i++) begin
            ob   = op_b_sel ? rs2 : imm;
            lsbi = (x_of(i) == 64) ? int'(lsb) : int'(lsb[1:0]);
            chk($sformatf("op_b[%0d]", i), 64'(obs_opb[i]), 64'(ob) & wmask(w_of(i)));
            chk($sformatf("dat[%0d]", i), obs_dat[i], mmod[i]);
            chk($sformatf("q[%0d] lsb=%0d", i, lsbi), 64'(obs_q[i]),
                (mmod[i] >> (8 * lsbi)) & wmask(w_of(i)));
            if (load)
               mmod[i] = idat & xmask(x_of(i));
            else if (en && bv)
               mmod[i] = mshift(mmod[i], w_of(i), x_of(i), ob);
         end
         @(negedge clk);
      end
      for (int i = 0; i < NI; i++)
         chk($sformatf("dat_end[%0d]", i), obs_dat[i], mmod[i]);

      // store alignment, W=1
      wd = 32'hA5A5_1234;
      load = 1'b0; en = 1'b1; bv = 1'b1; op_b_sel = 1'b0; init = 1'b0;
      for (int k = 0; k < 32; k++) begin
         imm = 8'(wd[k]);
         @(negedge clk);
      end
      en = 1'b0;
      chk("store_align_w1", obs_dat[0], 64'hA5A5_1234);

      // load with lane select; shift enables held high to exercise priority
      en = 1'b1; bv = 1'b1; load = 1'b1; idat = 64'h0000_0000_1122_3344; lsb = 3'd2;
      @(negedge clk);
      load = 1'b0; en = 1'b0;
      #1;
      chk("load_dat_w8", obs_dat[3], 64'h1122_3344);
      chk("load_q_w8_lsb2", 64'(obs_q[3]), 64'h22);
      en = 1'b1; load = 1'b1; idat = 64'h0123_4567_89AB_CDEF; lsb = 3'd7;
      @(negedge clk);
      load = 1'b0; en = 1'b0;
      #1;
      chk("load_dat_x64", obs_dat[4], 64'h0123_4567_89AB_CDEF);
      chk("load_q_x64_lsb7", 64'(obs_q[4]), 64'h01);

      // shift counter
      bv = 1'b0; en = 1'b1; op_b_sel = 1'b1;
      @(negedge clk);
      run_shift(2, 64'h1234_560D, 1'b1);
      run_shift(1, 64'hABCD_EFE0, 1'b1);
      run_shift(3, 64'h0000_0017, 1'b0);
      for (int r = 0; r < 10; r++) begin
         ii = $urandom_range(0, NI - 1);
         run_shift(ii, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      // reset while counting
      right = 1'b0;
      start_fill(0, 64'hCAFE_0014);
      chk("mid_busy", 64'(obs_busy[0]), 64'd1);
      chk("mid_cnt", 64'(g_dut[0].dut.u_shcnt.cnt_q), 64'd20);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(obs_busy[0]), 64'd0);
      chk("arst_cnt", 64'(g_dut[0].dut.u_shcnt.cnt_q), 64'd0);
      chk("arst_shd", 64'(obs_shd[0]), 64'd0);
      chk("arst_shdr", 64'(obs_shdr[0]), 64'd0);
      chk("arst_dat", obs_dat[0], 64'd0);
      chk("arst_q", 64'(obs_q[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 64'(obs_busy[0]), 64'd0);
      @(negedge clk);
      chk("post_rst_busy2", 64'(obs_busy[0]), 64'd0);
      chk("post_rst_shd", 64'(obs_shd[0]), 64'd0);
      shift_op = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serv_bufreg3.md
SERV_BUFREG3 -- requirements
Module: serv_bufreg3

Interface
REQ-001 SHALL have parameter W, default 1, meaning bits per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter XLEN, default 32, meaning data width; legal values 32, 64.
REQ-003 SHALL derive localparams SHW = $clog2(XLEN), LB = $clog2(W) and BW = $clog2(XLEN/8).
REQ-004 SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports i_en, i_init, i_cnt_done, i_byte_valid, i_op_b_sel, i_shift_op, i_right_shift_op and i_load, input, 1 bit each: core state and control strobes.
REQ-007 SHALL have port i_lsb, input, BW bits: byte offset of the access.
REQ-008 SHALL have ports i_rs2 and i_imm, input, W bits each: serial operand sources.
REQ-009 SHALL have port o_op_b, output, W bits: selected serial operand.
REQ-010 SHALL have port o_q, output, W bits: byte-lane-aligned serial data out.
REQ-011 SHALL have ports o_sh_done and o_sh_done_r, output, 1 bit each: shift complete, combinational and registered.
REQ-012 SHALL have port o_shift_rem, output, max(LB,1) bits: shift amount mod W; 0 when W=1.
REQ-013 SHALL have port o_busy, output, 1 bit: shift counter active (state COUNT or DONE).
REQ-014 SHALL have ports o_dat (output) and i_dat (input), XLEN bits each: bus data.

Function
REQ-015 SHALL drive o_op_b = i_op_b_sel ? i_rs2 : i_imm, combinationally.
REQ-016 SHALL, when (i_en & i_byte_valid) | (state==FILL) and !i_load, shift dat right by W with o_op_b entering dat[XLEN-1 -: W].
REQ-017 SHALL, on i_load, capture dat <= i_dat; i_load takes priority over shifting in the same cycle.
REQ-018 SHALL drive o_q = dat[8*i_lsb +: W] and o_dat = dat, combinationally.
REQ-019 SHALL hold the shift counter cnt in a dedicated (SHW+1)-bit register, independent of dat.
REQ-020 SHALL use FSM states IDLE, FILL, REM, COUNT and DONE.
REQ-021 SHALL transition IDLE->FILL when i_init & i_en & i_shift_op.
REQ-022 SHALL, in FILL on i_cnt_done, load cnt <= {1'b0, shamt}, where shamt is the low SHW bits of the post-shift dat value, and go to REM if i_right_shift_op & (shamt mod W != 0), else to COUNT.
REQ-023 SHALL, in REM, hold cnt for exactly one cycle with o_shift_rem valid, then go to COUNT.
REQ-024 SHALL, in COUNT, update cnt <= cnt - W each cycle (SHW+1-bit wrap).
REQ-025 SHALL, in COUNT, drive o_sh_done = MSB of (cnt - W); o_sh_done SHALL be 0 in all other states.
REQ-026 SHALL drive o_sh_done_r = cnt[SHW], registered.
REQ-027 SHALL transition COUNT->DONE when o_sh_done=1; in DONE, cnt is held.
REQ-028 SHALL return to IDLE and clear cnt from any state the cycle i_shift_op is seen low.
REQ-029 SHALL, for shamt=0, assert o_sh_done in the first COUNT cycle.
REQ-030 SHALL drive o_shift_rem = shamt[LB-1:0], held from FILL exit until IDLE; 0 otherwise.

Reset
REQ-031 SHALL, on i_rst, asynchronously clear dat, cnt and the o_shift_rem holding register, and set state=IDLE.
REQ-032 SHALL, during reset, hold o_sh_done=0, o_sh_done_r=0, o_busy=0, o_q=0 and o_dat=0.
REQ-033 SHALL, when reset deasserts mid-shift, start in IDLE with no partial count resumed.

Structure
REQ-034 SHALL define the FSM state enum and the legal W/XLEN checks in shared package serv_pkg.
REQ-035 SHALL implement the shift counter and FSM as sub-module serv_shcnt; the data register SHALL stay in serv_bufreg3.

Verification
REQ-036 SHALL cover store alignment: W=1, XLEN=32, shift in 0xA5A5_1234 over 32 cycles -> o_dat=0xA5A5_1234.
REQ-037 SHALL cover load lane select: i_load with i_dat=0x1122_3344, i_lsb=2, W=8 -> o_q=0x22.
REQ-038 SHALL cover shift of 13 with W=4, right shift: shamt=13 -> one REM cycle with o_shift_rem=1, then o_sh_done on the 4th COUNT cycle.
REQ-039 SHALL cover zero shift: shamt=0, W=2 -> o_sh_done=1 in the first COUNT cycle.
REQ-040 SHALL cover reset mid-operation: i_rst pulsed in COUNT with cnt=20 -> state=IDLE, o_busy=0, cnt=0 immediately, before the next clock edge.
REQ-041 SHALL cover XLEN=64: i_load with 0x0123_4567_89AB_CDEF, i_lsb=7, W=8 -> o_q=0x01.
